// File: rtl/key_switch_debouncer_pkg.sv
// Shared constants for the key/switch debouncer: default timing values,
// per-channel FSM state encoding and a counter-width helper.
package key_switch_debouncer_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_REPEAT_CYCLES   = 12500000;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_e;

  // Width for a counter that must reach cycles-1; never narrower than 1 bit.
  function automatic int cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_switch_debouncer_channel.sv
// One debounced input: 2-flop synchronizer, optional inversion, stability
// FSM with saturating counter, registered level and one-cycle edge strobes.
module debounce_channel
  import key_switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit POLARITY_INVERT = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          in_act;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Synchronizer resets to the raw "inactive" level so reset never looks like an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= {2{POLARITY_INVERT}};
    else       sync_q <= {sync_q[0], raw_i};
  end

  assign in_act = sync_q[1] ^ POLARITY_INVERT;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: if (in_act) begin
        state_d = PEND_HI;
        cnt_d   = '0;
      end
      PEND_HI: begin
        if (!in_act) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE_HI: if (!in_act) begin
        state_d = PEND_LO;
        cnt_d   = '0;
      end
      PEND_LO: begin
        if (in_act) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/key_switch_debouncer.sv
// Debounces active-low pushbuttons and slide switches into clean levels and strobes.
// Define KEY_AUTOREPEAT_EN to re-fire key_press every REPEAT_CYCLES while a key is held.
module key_switch_debouncer
  import key_switch_debouncer_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_SWITCHES    = 8,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_KEYS-1:0]     key_n,
  input  logic [NUM_SWITCHES-1:0] switch,
  output logic [NUM_KEYS-1:0]     key_level,
  output logic [NUM_KEYS-1:0]     key_press,
  output logic [NUM_KEYS-1:0]     key_release,
  output logic [NUM_SWITCHES-1:0] switch_level,
  output logic [NUM_SWITCHES-1:0] switch_change
);

  logic [NUM_KEYS-1:0]     key_rise;
  logic [NUM_SWITCHES-1:0] sw_rise, sw_fall;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .POLARITY_INVERT (1'b1)
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (key_n[g]),
      .level_o (key_level[g]),
      .rise_o  (key_rise[g]),
      .fall_o  (key_release[g])
    );
  end

  for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_sw
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .POLARITY_INVERT (1'b0)
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (switch[g]),
      .level_o (switch_level[g]),
      .rise_o  (sw_rise[g]),
      .fall_o  (sw_fall[g])
    );
  end

  assign switch_change = sw_rise | sw_fall;

`ifdef KEY_AUTOREPEAT_EN
  localparam int            RW       = cnt_w(REPEAT_CYCLES);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

  logic [NUM_KEYS-1:0][RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [NUM_KEYS-1:0]         rpt_fire_q, rpt_fire_d;

  // Counter starts the cycle after the press strobe, so repeats land every REPEAT_CYCLES.
  always_comb begin
    rpt_cnt_d  = rpt_cnt_q;
    rpt_fire_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!key_level[i]) begin
        rpt_cnt_d[i] = '0;
      end else if (rpt_cnt_q[i] == RPT_LAST) begin
        rpt_cnt_d[i]  = '0;
        rpt_fire_d[i] = 1'b1;
      end else begin
        rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rpt_cnt_q  <= '0;
      rpt_fire_q <= '0;
    end else begin
      rpt_cnt_q  <= rpt_cnt_d;
      rpt_fire_q <= rpt_fire_d;
    end
  end

  assign key_press = key_rise | rpt_fire_q;
`else
  logic unused_repeat_cycles;
  assign unused_repeat_cycles = ^REPEAT_CYCLES;
  assign key_press = key_rise;
`endif

endmodule

// File: tb/tb_key_switch_debouncer.sv
// Directed bench for key_switch_debouncer with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
module tb_key_switch_debouncer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic [7:0] switch;
  logic [3:0] key_level, key_press, key_release;
  logic [7:0] switch_level, switch_change;

  always #5 clock = ~clock;

  key_switch_debouncer #(
    .NUM_KEYS        (4),
    .NUM_SWITCHES    (8),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .key_n         (key_n),
    .switch        (switch),
    .key_level     (key_level),
    .key_press     (key_press),
    .key_release   (key_release),
    .switch_level  (switch_level),
    .switch_change (switch_change)
  );

  typedef struct {
    logic [3:0] kn;
    logic [7:0] sw;
    int         cyc;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [7:0] swl;
    logic [7:0] swc;
  } vec_t;

  vec_t vecs[19];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   press_cnt[4] = '{default: 0};
  int   rel_cnt[4]   = '{default: 0};

  // Strobe tally: a strobe stretched or duplicated shows up as an extra count.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      for (int i = 0; i < 4; i++) begin
        press_cnt[i] += int'(key_press[i]);
        rel_cnt[i]   += int'(key_release[i]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                         input logic [3:0] rel, input logic [7:0] swl, input logic [7:0] swc);
    chk({tag, ".key_level"},     32'(key_level),     32'(lvl));
    chk({tag, ".key_press"},     32'(key_press),     32'(prs));
    chk({tag, ".key_release"},   32'(key_release),   32'(rel));
    chk({tag, ".switch_level"},  32'(switch_level),  32'(swl));
    chk({tag, ".switch_change"}, 32'(switch_change), 32'(swc));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    // Inputs change 1 time unit after a clock edge; the next edge samples them (edge 0).
    // A clean change is accepted on edge 6: two sync flops, one PEND entry, four counts.
    vecs[0]  = '{4'hF, 8'h03,  6, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00};
    vecs[1]  = '{4'hF, 8'h03,  1, 4'h0, 4'h0, 4'h0, 8'h03, 8'h03};
    vecs[2]  = '{4'hF, 8'h03,  1, 4'h0, 4'h0, 4'h0, 8'h03, 8'h00};
    vecs[3]  = '{4'hE, 8'h03,  6, 4'h0, 4'h0, 4'h0, 8'h03, 8'h00};
    vecs[4]  = '{4'hE, 8'h03,  1, 4'h1, 4'h1, 4'h0, 8'h03, 8'h00};
    vecs[5]  = '{4'hE, 8'h03,  1, 4'h1, 4'h0, 4'h0, 8'h03, 8'h00};
    vecs[6]  = '{4'hE, 8'h03, 14, 4'h1, 4'h0, 4'h0, 8'h03, 8'h00};
    vecs[7]  = '{4'hF, 8'h03,  6, 4'h1, 4'h0, 4'h0, 8'h03, 8'h00};
    vecs[8]  = '{4'hF, 8'h03,  1, 4'h0, 4'h0, 4'h1, 8'h03, 8'h00};
    vecs[9]  = '{4'hF, 8'h03,  1, 4'h0, 4'h0, 4'h0, 8'h03, 8'h00};
    vecs[10] = '{4'h9, 8'h03,  6, 4'h0, 4'h0, 4'h0, 8'h03, 8'h00};
    vecs[11] = '{4'h9, 8'h03,  1, 4'h6, 4'h6, 4'h0, 8'h03, 8'h00};
    vecs[12] = '{4'h9, 8'h03,  1, 4'h6, 4'h0, 4'h0, 8'h03, 8'h00};
    vecs[13] = '{4'hF, 8'h03,  6, 4'h6, 4'h0, 4'h0, 8'h03, 8'h00};
    vecs[14] = '{4'hF, 8'h03,  1, 4'h0, 4'h0, 4'h6, 8'h03, 8'h00};
    vecs[15] = '{4'hF, 8'h03,  1, 4'h0, 4'h0, 4'h0, 8'h03, 8'h00};
    vecs[16] = '{4'hF, 8'h81,  6, 4'h0, 4'h0, 4'h0, 8'h03, 8'h00};
    vecs[17] = '{4'hF, 8'h81,  1, 4'h0, 4'h0, 4'h0, 8'h81, 8'h82};
    vecs[18] = '{4'hF, 8'h81,  1, 4'h0, 4'h0, 4'h0, 8'h81, 8'h00};

    reset  = 1'b1;
    key_n  = 4'hF;
    switch = 8'h03;
    step(3);
    chk_all("in_reset", 4'h0, 4'h0, 4'h0, 8'h00, 8'h00);
    reset = 1'b0;

    for (int v = 0; v < 19; v++) begin
      key_n  = vecs[v].kn;
      switch = vecs[v].sw;
      step(vecs[v].cyc);
      chk_all($sformatf("vec%0d", v), vecs[v].lvl, vecs[v].prs, vecs[v].rel,
              vecs[v].swl, vecs[v].swc);
    end

    // Bounce on key 1: 3 low / 1 high, last falling edge at i=12, then held low.
    for (int i = 0; i < 15; i++) begin
      key_n    = 4'hF;
      key_n[1] = ((i % 4) == 3);
      step(1);
      chk($sformatf("bounce%0d.key_press", i), 32'(key_press), 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk($sformatf("bounce_hold%0d.key_press", i), 32'(key_press), 32'h0);
    end
    step(1);
    chk("bounce_accept.key_press", 32'(key_press), 32'h2);
    chk("bounce_accept.key_level", 32'(key_level), 32'h2);
    key_n = 4'hF;
    step(8);
    chk("bounce_release.key_level", 32'(key_level), 32'h0);

    // Reset while key 0 is mid-debounce, with switches 8'h81 held on.
    key_n = 4'hE;
    step(5);
    chk("pend.key_level", 32'(key_level), 32'h0);
    chk("pend.key_press", 32'(key_press), 32'h0);
    reset = 1'b1;
    step(2);
    chk_all("mid_reset", 4'h0, 4'h0, 4'h0, 8'h00, 8'h00);
    reset = 1'b0;
    step(6);
    chk_all("post_reset_wait", 4'h0, 4'h0, 4'h0, 8'h00, 8'h00);
    step(1);
    chk_all("post_reset_accept", 4'h1, 4'h1, 4'h0, 8'h81, 8'h81);
    step(1);
    chk_all("post_reset_after", 4'h1, 4'h0, 4'h0, 8'h81, 8'h00);
    key_n = 4'hF;
    step(8);
    chk("post_reset_release.key_level", 32'(key_level), 32'h0);

    step(1);
`ifdef KEY_AUTOREPEAT_EN
    chk("total.press0", 32'(press_cnt[0]), 32'd4);
`else
    chk("total.press0", 32'(press_cnt[0]), 32'd2);
`endif
    chk("total.press1",   32'(press_cnt[1]), 32'd2);
    chk("total.press2",   32'(press_cnt[2]), 32'd1);
    chk("total.press3",   32'(press_cnt[3]), 32'd0);
    chk("total.release0", 32'(rel_cnt[0]),   32'd2);
    chk("total.release1", 32'(rel_cnt[1]),   32'd2);
    chk("total.release2", 32'(rel_cnt[2]),   32'd1);
    chk("total.release3", 32'(rel_cnt[3]),   32'd0);

`ifdef KEY_AUTOREPEAT_EN
    key_n = 4'hE;
    step(6);
    chk("rpt_wait.key_press", 32'(key_press), 32'h0);
    step(1);
    chk("rpt_initial.key_press", 32'(key_press), 32'h1);
    for (int k = 1; k <= 40; k++) begin
      step(1);
      chk($sformatf("rpt_hold%0d.key_press", k), 32'(key_press[0]), 32'(((k % 10) == 0)));
    end
    key_n = 4'hF;
    for (int k = 0; k < 12; k++) begin
      step(1);
      chk($sformatf("rpt_release%0d.key_press", k), 32'(key_press), 32'h0);
    end
    chk("rpt_release.key_level", 32'(key_level), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_switch_debouncer.md
Name: key_switch_debouncer

Overview:
- Board-side input conditioner for the DE-series pushbuttons (KEY, active-low) and slide switches (SW).
- Synchronizes each raw input to `clock`, filters contact bounce, and presents clean levels plus single-cycle press/release strobes.
- Sits between the fpga_top pins and the clock/reset/run-mode control logic and memory-mapped input peripherals.

Parameters:
- NUM_KEYS, 4, number of active-low pushbutton inputs.
- NUM_SWITCHES, 8, number of slide-switch inputs.
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized cycles required to accept a new level (1 ms at 50 MHz); legal range ≥ 2.
- REPEAT_CYCLES, 12500000, auto-repeat period; used only with the optional feature.

Ports:
- clock  input  1  system clock (CLOCK_50 domain).
- reset  input  1  asynchronous, active-high reset.
- key_n  input  NUM_KEYS  raw pushbuttons; 0 = pressed.
- switch  input  NUM_SWITCHES  raw slide switches; 1 = on.
- key_level  output  NUM_KEYS  debounced state; 1 = pressed.
- key_press  output  NUM_KEYS  one-cycle strobe on accepted press.
- key_release  output  NUM_KEYS  one-cycle strobe on accepted release.
- switch_level  output  NUM_SWITCHES  debounced switch state.
- switch_change  output  NUM_SWITCHES  one-cycle strobe on any accepted switch transition.

Behaviour:
- Reset:
  - Key synchronizer flops reset to 1 (released).
  - Switch synchronizer flops reset to 0.
  - All outputs reset to 0.
  - All counters reset to 0.
- Reset mid-operation:
  - Asserting reset aborts any pending debounce immediately.
  - After deassertion, a switch held on must be fully re-debounced. It produces one switch_change strobe when accepted.
  - A key held across reset produces a key_press strobe once it is accepted.
- Synchronizer: 2-flop per input; keys are inverted after synchronization so internal polarity is 1 = active.
- Per-channel FSM, identical for keys and switches:
  - STABLE_LO: output 0. Moves to PEND_HI when the synchronized input is 1 (counter cleared).
  - PEND_HI: counter increments each cycle while the input is 1. If the input drops to 0, go back to STABLE_LO (counter cleared). When the counter reaches DEBOUNCE_CYCLES-1 with the input still 1, go to STABLE_HI. In that transition, output rises and the rise strobe fires.
  - STABLE_HI / PEND_LO: mirror image of the two states above.
- Latency: raw edge sampled at cycle 0 → level and strobe registered at cycle 2+DEBOUNCE_CYCLES exactly, provided the input is clean.
- Glitch rule: any pulse or gap shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change and no strobe.
- Strobes: high for exactly one cycle, coincident with the first cycle of the new level.
  - key_press fires on 0→1 of key_level.
  - key_release fires on 1→0.
  - switch_change fires on either edge.
- Channels are independent. Simultaneous transitions on several channels strobe in the same cycle.
- Counter width: $clog2(DEBOUNCE_CYCLES). The counter saturates and never wraps.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - While key_level[i] = 1, a per-key repeat counter runs.
  - key_press[i] re-fires every REPEAT_CYCLES cycles after the initial press strobe.
  - The counter clears on release and on reset.
  - Switches are unaffected.
- Undefined: no repeat counters are built; key_press fires once per accepted press.

Decomposition:
- Shared constants go in config.v:
  - default DEBOUNCE_CYCLES / REPEAT_CYCLES values;
  - FSM state encodings (2-bit: STABLE_LO=0, PEND_HI=1, STABLE_HI=2, PEND_LO=3).
- One natural sub-module: debounce_channel. It holds the synchronizer, FSM, counter, level and edge strobes, and has a POLARITY_INVERT parameter.
- The top instantiates NUM_KEYS inverted and NUM_SWITCHES non-inverted channels in generate loops, plus the optional repeat logic.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10):
- Reset with key_n=4'b1111, switch=8'h03, then release reset:
  - all outputs 0 during reset;
  - switch_level becomes 8'h03 exactly 6 cycles after release;
  - switch_change=8'h03 strobes for 1 cycle;
  - no key strobes.
- Clean press, key_n 1111→1110 held 20 cycles:
  - key_level[0] rises 6 cycles after the edge;
  - key_press=4'b0001 for exactly 1 cycle.
- Clean release: key_release[0] strobes once, and key_level[0] returns to 0 6 cycles after key_n[0] returns to 1.
- Bounce: key_n[1] toggles with 3-cycle low, 1-cycle high pulses for 15 cycles, then holds low:
  - no strobe during the bounce;
  - key_press[1] fires once, 6 cycles after the final falling edge.
- Simultaneous: key_n 1111→1001 → key_press=4'b0110 in a single cycle.
- Reset asserted at cycle 3 of PEND_HI:
  - no strobe is issued;
  - after deassertion with key still held, key_press fires 6 cycles later.
- With KEY_AUTOREPEAT_EN defined, holding key 0 for 40 cycles gives key_press[0] strobes spaced 10 cycles apart after the initial one, and none after release.
